// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) constants used by the encoder and the downstream decoder.
// Codewords are indexed [7:1] so that bit positions match the textbook numbering.
package hamming_pkg;

  localparam int CW_W = 7;
  localparam int DW   = 4;

  // Parity positions.
  localparam int P1 = 1;
  localparam int P2 = 2;
  localparam int P4 = 4;

  // Data positions; DATA_POS[i] is the codeword position of data bit i.
  localparam int D0_POS = 3;
  localparam int D1_POS = 5;
  localparam int D2_POS = 6;
  localparam int D3_POS = 7;

  // Syndrome {s4,s2,s1} equals the position of a single flipped bit; zero means clean.
  localparam int SYND_W     = 3;
  localparam int SYND_CLEAN = 0;

  typedef logic [CW_W:1]     codeword_t;
  typedef logic [DW-1:0]     nibble_t;
  typedef logic [SYND_W-1:0] inj_pos_t;

  function automatic codeword_t hamming74_encode(input nibble_t d);
    codeword_t c;
    c         = '0;
    c[D0_POS] = d[0];
    c[D1_POS] = d[1];
    c[D2_POS] = d[2];
    c[D3_POS] = d[3];
    c[P1]     = d[0] ^ d[1] ^ d[3];
    c[P2]     = d[0] ^ d[2] ^ d[3];
    c[P4]     = d[1] ^ d[2] ^ d[3];
    return c;
  endfunction

endpackage

// File: rtl/hamming74_enc.sv
// Combinational Hamming(7,4) encoder with optional single-bit error injection.
// inj_pos_i = 0 leaves the codeword clean; 1..7 inverts that codeword position.
module hamming74_enc
  import hamming_pkg::*;
(
  input  logic [DW-1:0]     data_i,
  input  logic [SYND_W-1:0] inj_pos_i,
  output logic [CW_W:1]     code_o
);

  codeword_t clean;

  always_comb begin
    clean  = hamming74_encode(data_i);
    code_o = clean;
    for (int p = 1; p <= CW_W; p++) begin
      if (int'(inj_pos_i) == p) begin
        code_o[p] = ~clean[p];
      end
    end
  end

endmodule

// File: rtl/hamming_encoder_fifo.sv
// Encodes nibbles into Hamming(7,4) codewords and buffers them for the decoder.
// All outputs come from registered state; no input-to-output combinational path.
module hamming_encoder_fifo
  import hamming_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [DW-1:0]            din_i,
  input  logic                     din_valid_i,
  output logic                     din_ready_o,
  input  logic [SYND_W-1:0]        inj_pos_i,
  output logic [CW_W:1]            code_o,
  output logic                     code_valid_o,
  input  logic                     code_ready_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [CNT_W-1:0]         word_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] WCNT_ONE = CNT_W'(1);

  codeword_t         mem_q [DEPTH];
  codeword_t         enc_word;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic              push, pop;

  hamming74_enc u_enc (
    .data_i    (din_i),
    .inj_pos_i (inj_pos_i),
    .code_o    (enc_word)
  );

  assign din_ready_o  = (count_q < CNT_FULL);
  assign code_valid_o = (count_q != '0);
  assign push         = din_valid_i && din_ready_o;
  assign pop          = code_valid_o && code_ready_i;

  assign code_o     = code_valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o    = count_q;
  assign word_cnt_o = word_cnt_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    word_cnt_d = word_cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
      word_cnt_d = word_cnt_q + WCNT_ONE;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      word_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  // Storage needs no reset: entries are only visible while count_q covers them.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && push) begin
      mem_q[wr_ptr_q] <= enc_word;
    end
  end

endmodule

// File: doc/hamming_encoder_fifo.md
# hamming_encoder_fifo

- Upstream stage of the 7-bit Hamming decoder.
- Accepts 4-bit data nibbles over a valid/ready handshake and encodes each as a Hamming(7,4) codeword in D[7:1] bit order (parity at positions 1, 2, 4).
- Optionally flips one codeword bit for decoder error testing.
- Buffers codewords in a small FIFO and presents them to the decoder over a second valid/ready handshake, with occupancy and sent-word counters.

## Interface
- DEPTH, 4, FIFO entries; power of two, 2..16.
- CNT_W, 16, width of WORD_CNT.
- CLK  input  1  sole clock; all state updates on rising edge.
- RST_N  input  1  synchronous, active-low reset; sampled on CLK rising edge.
- DIN  input  4  data nibble; DIN[0..3] map to codeword positions 3, 5, 6, 7.
- DIN_VALID  input  1  DIN valid this cycle.
- DIN_READY  output  1  block can accept DIN this cycle.
- INJ_POS  input  3  sampled with DIN; 0 = no injection, 1..7 = invert that codeword bit before storing.
- CODE  output  7  codeword [7:1] at FIFO head; 0 when empty.
- CODE_VALID  output  1  CODE valid.
- CODE_READY  input  1  downstream (decoder) consumes CODE this cycle.
- COUNT  output  $clog2(DEPTH)+1  current FIFO occupancy.
- WORD_CNT  output  CNT_W  codewords popped since reset; wraps to 0.

## Operation
- Encoding uses C3=DIN[0], C5=DIN[1], C6=DIN[2], C7=DIN[3].
  - C1 = C3^C5^C7
  - C2 = C3^C6^C7
  - C4 = C5^C6^C7
- Injection: if INJ_POS≠0, the stored word is C with bit C[INJ_POS] inverted. The inversion is applied at push and is fixed thereafter.
- Push when DIN_VALID && DIN_READY. Pop when CODE_VALID && CODE_READY.
- DIN_READY = (COUNT < DEPTH). It depends only on registered state, never on CODE_READY.
- CODE_VALID = (COUNT ≠ 0). CODE and CODE_VALID are driven from registered state only. No combinational path from any input to any output.
- Simultaneous push and pop with 0 < COUNT < DEPTH: both occur and COUNT is unchanged.
- When full, a pop frees a slot that becomes visible next cycle. There is no same-cycle push-through.
- When empty, a push is not visible until the next cycle. There is no fall-through.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. COUNT is a separate counter.
- Order is strictly FIFO.
- WORD_CNT increments on each pop and wraps from 2^CNT_W−1 to 0.
- DIN_VALID while DIN_READY=0 is ignored. It is not an error, and the upstream must hold DIN.

## Timing
- Reset (RST_N=0 at an edge):
  - COUNT=0, WORD_CNT=0, pointers=0.
  - CODE_VALID=0, CODE=0, DIN_READY=1.
  - Applies from the first edge with RST_N low, including mid-operation. Buffered words are discarded and any same-cycle push or pop is dropped.
- Latency: a nibble pushed at edge k into an empty FIFO gives CODE_VALID=1 and the correct CODE after edge k, i.e. one cycle.
- Throughput: one push and one pop per cycle sustained.
- CODE is stable while CODE_VALID=1 and CODE_READY=0.

## Structure
- Shared package hamming_pkg:
  - parity-position constants (P1=1, P2=2, P4=4)
  - data-position constants (3, 5, 6, 7)
  - codeword width constant 7
  - the same constants the decoder uses for syndrome mapping
- Sub-module hamming74_enc: purely combinational; 4-bit data plus INJ_POS in, 7-bit codeword out. Instantiated once at the FIFO write port.
- FIFO storage, pointers and counters stay in the top module.

## Test plan
- Reset then push DIN=4'b1011, INJ_POS=0, CODE_READY=1 → one cycle later CODE=7'b1010101, CODE_VALID=1. Next cycle WORD_CNT=1 and COUNT=0.
- Push 0000, 1111, 0001 back-to-back with CODE_READY=0 → COUNT=3. Then CODE_READY=1 → CODE sequence 7'b0000000, 7'b1111111, 7'b0000111.
- DIN=4'b1011, INJ_POS=3 → CODE=7'b1010001; the decoder downstream flags Error and recovers 7'b1010101.
- CODE_READY=0, push DEPTH words → DIN_READY=0, COUNT=DEPTH. A further DIN_VALID is not accepted. One pop → DIN_READY=1 next cycle, no data loss or reorder.
- COUNT=2 with simultaneous push and pop every cycle for 20 cycles → COUNT stays 2, order preserved, pointers wrap correctly.
- RST_N=0 for one edge with COUNT=3 → next cycle COUNT=0, CODE_VALID=0, CODE=0, WORD_CNT=0, DIN_READY=1. A fresh push then behaves as in the first scenario.
